// File: rtl/blockade_sound.sv
// rtl/blockade_sound.sv - movement-tone chain and crash-noise latch mixed into one signed sample stream
module blockade_sound #(
  parameter int          TONE_HIGH = 140,
  parameter int          TONE_LOW  = 51,
  parameter int          TONE_AMP  = 15000,
  parameter int          NOISE_AMP = 15000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        outp,
  input  logic [3:0]  port_addr,
  input  logic [7:0]  port_data,
  output logic        tick,
  output logic        tone,
  output logic        noise_on,
  output logic [15:0] audio_out
);

  localparam int PERIOD = TONE_HIGH + TONE_LOW;
  localparam int PW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PERIOD - 1);
  localparam logic signed [17:0] T_AMP     = 18'(TONE_AMP);
  localparam logic signed [17:0] N_AMP     = 18'(NOISE_AMP);
  localparam logic signed [17:0] T_NEG     = -T_AMP;
  localparam logic signed [17:0] SAT_HI    = 18'sd32767;
  localparam logic signed [17:0] SAT_LO    = -18'sd32768;

  logic [PW-1:0] presc;
  logic [7:0]    pitch;
  logic [7:0]    count;
  logic          ovf;
  logic [15:0]   lfsr;
  logic          wrap;

  logic signed [17:0] t_val;
  logic signed [17:0] n_val;
  logic signed [17:0] sum;
  logic [15:0]        sample;

  // The 555 edge is the clk where the prescaler wraps; every tick-driven stage steps on that same edge.
  assign wrap = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      tick      <= 1'b0;
      pitch     <= 8'h00;
      count     <= 8'h00;
      ovf       <= 1'b0;
      tone      <= 1'b0;
      noise_on  <= 1'b0;
      lfsr      <= LFSR_SEED;
      audio_out <= T_NEG[15:0];
    end else begin
      presc     <= wrap ? '0 : presc + 1'b1;
      tick      <= wrap;
      audio_out <= sample;

      if (outp && port_addr[1])
        pitch <= port_data;

      // Set input dominates, like the NAND latch with both inputs pulled low.
      if (outp && port_addr[3])
        noise_on <= 1'b1;
      else if (outp && port_addr[2])
        noise_on <= 1'b0;

      if (wrap) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (ovf) begin
          count <= pitch;
          ovf   <= 1'b0;
        end else begin
          count <= count + 8'd1;
          ovf   <= (count == 8'hFF);
          if (count == 8'hFF)
            tone <= ~tone;
        end
      end
    end
  end

  always_comb begin
    t_val  = tone ? T_AMP : T_NEG;
    n_val  = '0;
    if (noise_on)
      n_val = lfsr[15] ? N_AMP : -N_AMP;
    sum    = t_val + n_val;
    sample = sum[15:0];
    if (sum > SAT_HI)
      sample = 16'h7FFF;
    else if (sum < SAT_LO)
      sample = 16'h8000;
  end

endmodule

// File: tb/tb_blockade_sound.sv
// tb/tb_blockade_sound.sv - randomized bench against a tick-indexed reference model of blockade_sound
module tb_blockade_sound;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        outp = 1'b0;
  logic [3:0]  port_addr = 4'h0;
  logic [7:0]  port_data = 8'h00;

  logic        tick, tone, noise_on;
  logic [15:0] audio_out;
  logic        tick_c, tone_c, noise_c;
  logic [15:0] audio_c;

  always #5 clk = ~clk;

  blockade_sound dut (
    .clk(clk), .reset_n(reset_n), .outp(outp), .port_addr(port_addr), .port_data(port_data),
    .tick(tick), .tone(tone), .noise_on(noise_on), .audio_out(audio_out)
  );

  // Louder variant so that tone plus noise exceeds the 16-bit range and must saturate.
  blockade_sound #(.TONE_AMP(20000), .NOISE_AMP(20000)) dut_c (
    .clk(clk), .reset_n(reset_n), .outp(outp), .port_addr(port_addr), .port_data(port_data),
    .tick(tick_c), .tone(tone_c), .noise_on(noise_c), .audio_out(audio_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: tone events are scheduled by tick index rather than by emulating the counter.
  int          cyc, tick_idx, next_toggle, next_reload;
  bit          m_tick, m_tone, m_noise;
  logic [15:0] m_lfsr;
  logic [7:0]  m_pitch;
  int          m_audio, m_audio_c;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mix(input bit t, input bit n, input bit b, input int at, input int an);
    int s;
    s = t ? at : -at;
    if (n) s += b ? an : -an;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_reset();
    cyc = 0; tick_idx = 0; next_toggle = 256; next_reload = 257;
    m_tick = 0; m_tone = 0; m_noise = 0; m_lfsr = 16'hACE1; m_pitch = 8'h00;
    m_audio = -15000; m_audio_c = -20000;
  endtask

  task automatic model_edge();
    int a, ac;
    a  = mix(m_tone, m_noise, m_lfsr[15], 15000, 15000);
    ac = mix(m_tone, m_noise, m_lfsr[15], 20000, 20000);
    cyc++;
    m_tick = (cyc % 191 == 0);
    if (m_tick) begin
      tick_idx++;
      if (tick_idx == next_toggle) m_tone = ~m_tone;
      if (tick_idx == next_reload) begin
        next_toggle = tick_idx + 256 - int'(m_pitch);
        next_reload = tick_idx + 257 - int'(m_pitch);
      end
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end
    m_audio = a;
    m_audio_c = ac;
    if (outp && port_addr[1]) m_pitch = port_data;
    if (outp && port_addr[3]) m_noise = 1;
    else if (outp && port_addr[2]) m_noise = 0;
  endtask

  task automatic check_all();
    check("tick",      int'(tick),           int'(m_tick));
    check("tone",      int'(tone),           int'(m_tone));
    check("noise_on",  int'(noise_on),       int'(m_noise));
    check("audio",     $signed(audio_out),   m_audio);
    check("tick_c",    int'(tick_c),         int'(m_tick));
    check("tone_c",    int'(tone_c),         int'(m_tone));
    check("noise_c",   int'(noise_c),        int'(m_noise));
    check("audio_sat", $signed(audio_c),     m_audio_c);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    outp = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      if (((cyc + 1) % 191 == 0) && (tick_idx + 1 == next_reload)) begin
        outp = 1'b1; port_addr = 4'h2; port_data = 8'($urandom_range(192, 255));
      end else if ($urandom_range(0, 99) < 2) begin
        outp = 1'b1; port_addr = 4'($urandom_range(0, 15)); port_data = 8'($urandom_range(192, 255));
      end else begin
        outp = 1'b0;
      end
      cycle();
    end
    outp = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    repeat (30000) cycle();
    outp = 1'b1; port_addr = 4'h2; port_data = 8'hF0;
    repeat (2) cycle();
    outp = 1'b0;
    repeat (19200) cycle();

    outp = 1'b1; port_addr = 4'h8; cycle(); outp = 1'b0;
    repeat (3000) cycle();
    outp = 1'b1; port_addr = 4'h4; cycle(); outp = 1'b0;
    repeat (1000) cycle();
    outp = 1'b1; port_addr = 4'hC; cycle(); outp = 1'b0;
    repeat (2000) cycle();

    random_run(6000);
    do_reset();
    random_run(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
